axi4l_regfile: RTL and testbench

Parametrised AXI4-Lite slave register bank: NUM_REGS word registers, each either software read/write (driving fabric logic) or read-only (sampled from fabric logic), with byte-strobe writes, independent write-address/write-data acceptance and SLVERR signalling. It is the standard control/status endpoint behind the AXI4-Lite interconnect and replaces hand-written per-design register decoders.

---
 rtl/axi4l_regfile.sv | 189 ++++++++++++++++++
 tb/tb_axi4l_regfile.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4l_regfile.sv
// AXI4-Lite slave register bank: R/W registers drive reg_out, read-only slots return reg_in.
// Write address and data are captured independently; at most one write and one read outstanding.
module axi4l_regfile #(
  parameter int                  ADDR_WIDTH = 32,
  parameter int                  DATA_WIDTH = 32,
  parameter int                  NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK    = {NUM_REGS{1'b0}}
) (
  input  logic                           axi4l_aclk,
  input  logic                           axi4l_arst,
  input  logic [ADDR_WIDTH-1:0]          awaddr,
  input  logic                           awvalid,
  output logic                           awready,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [DATA_WIDTH/8-1:0]        wstrb,
  input  logic                           wvalid,
  output logic                           wready,
  output logic [1:0]                     bresp,
  output logic                           bvalid,
  input  logic                           bready,
  input  logic [ADDR_WIDTH-1:0]          araddr,
  input  logic                           arvalid,
  output logic                           arready,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [1:0]                     rresp,
  output logic                           rvalid,
  input  logic                           rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_in,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int LSB        = $clog2(STRB_WIDTH);
  localparam int IDXW       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [IDXW:0] NUM_REGS_W  = (IDXW + 1)'(NUM_REGS);
  localparam logic [1:0]    RESP_OKAY   = 2'b00;
  localparam logic [1:0]    RESP_SLVERR = 2'b10;

  function automatic logic [IDXW-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] addr);
    return addr[LSB +: IDXW];
  endfunction

  // In range only when no bit above the index field is set and the index names a real register.
  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] upper;
    upper = addr >> (LSB + IDXW);
    return (upper == {ADDR_WIDTH{1'b0}}) && ({1'b0, addr[LSB +: IDXW]} < NUM_REGS_W);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] merge_strb(input logic [DATA_WIDTH-1:0] old_v,
                                                       input logic [DATA_WIDTH-1:0] new_v,
                                                       input logic [STRB_WIDTH-1:0] strb);
    logic [DATA_WIDTH-1:0] res;
    for (int b = 0; b < STRB_WIDTH; b++) begin
      res[b*8 +: 8] = strb[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
    end
    return res;
  endfunction

  logic [DATA_WIDTH-1:0] regs_r   [NUM_REGS];
  logic [DATA_WIDTH-1:0] reg_in_s [NUM_REGS];

  logic                  aw_held_r, w_held_r, aw_ok_r;
  logic [IDXW-1:0]       aw_idx_r;
  logic [DATA_WIDTH-1:0] wdata_r;
  logic [STRB_WIDTH-1:0] wstrb_r;
  logic                  awready_r, wready_r, bvalid_r;
  logic [1:0]            bresp_r;
  logic [NUM_REGS-1:0]   wr_pulse_r;
  logic                  arready_r, rvalid_r;
  logic [DATA_WIDTH-1:0] rdata_r;
  logic [1:0]            rresp_r;

  logic                  aw_hs_s, w_hs_s, ar_hs_s, commit_s;
  logic                  aw_held_nx_s, w_held_nx_s, bvalid_nx_s, rvalid_nx_s;
  logic [IDXW-1:0]       aw_idx_s, ar_idx_s;
  logic                  ar_ok_s;
  logic [DATA_WIDTH-1:0] rd_val_s;

  assign aw_hs_s  = awvalid && awready_r;
  assign w_hs_s   = wvalid && wready_r;
  assign ar_hs_s  = arvalid && arready_r;
  assign commit_s = aw_held_r && w_held_r;
  assign aw_idx_s = addr_idx(awaddr);

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_slot
    assign reg_in_s[i] = reg_in[i*DATA_WIDTH +: DATA_WIDTH];
    assign reg_out[i*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[i] ? {DATA_WIDTH{1'b0}} : regs_r[i];
  end

  // Write-side next state: holds fill on handshake and drain together on commit.
  always_comb begin
    aw_held_nx_s = aw_held_r;
    w_held_nx_s  = w_held_r;
    bvalid_nx_s  = bvalid_r;
    if (commit_s) begin
      aw_held_nx_s = 1'b0;
      w_held_nx_s  = 1'b0;
      bvalid_nx_s  = 1'b1;
    end else begin
      if (aw_hs_s) aw_held_nx_s = 1'b1; else aw_held_nx_s = aw_held_r;
      if (w_hs_s) w_held_nx_s = 1'b1; else w_held_nx_s = w_held_r;
      if (bvalid_r && bready) bvalid_nx_s = 1'b0; else bvalid_nx_s = bvalid_r;
    end
  end

  // Write channel registers, register bank and write strobes.
  always_ff @(posedge axi4l_aclk) begin
    if (axi4l_arst) begin
      aw_held_r  <= 1'b0;
      w_held_r   <= 1'b0;
      aw_ok_r    <= 1'b0;
      aw_idx_r   <= {IDXW{1'b0}};
      wdata_r    <= {DATA_WIDTH{1'b0}};
      wstrb_r    <= {STRB_WIDTH{1'b0}};
      awready_r  <= 1'b0;
      wready_r   <= 1'b0;
      bvalid_r   <= 1'b0;
      bresp_r    <= RESP_OKAY;
      wr_pulse_r <= {NUM_REGS{1'b0}};
      for (int i = 0; i < NUM_REGS; i++) regs_r[i] <= {DATA_WIDTH{1'b0}};
    end else begin
      aw_held_r  <= aw_held_nx_s;
      w_held_r   <= w_held_nx_s;
      bvalid_r   <= bvalid_nx_s;
      awready_r  <= !aw_held_nx_s && !bvalid_nx_s;
      wready_r   <= !w_held_nx_s && !bvalid_nx_s;
      wr_pulse_r <= {NUM_REGS{1'b0}};
      if (aw_hs_s) begin
        aw_idx_r <= aw_idx_s;
        aw_ok_r  <= addr_ok(awaddr) && !RO_MASK[aw_idx_s];
      end
      if (w_hs_s) begin
        wdata_r <= wdata;
        wstrb_r <= wstrb;
      end
      if (commit_s) begin
        bresp_r <= aw_ok_r ? RESP_OKAY : RESP_SLVERR;
        if (aw_ok_r) begin
          regs_r[aw_idx_r]     <= merge_strb(regs_r[aw_idx_r], wdata_r, wstrb_r);
          wr_pulse_r[aw_idx_r] <= 1'b1;
        end
      end
    end
  end

  // Read decode; the bank is sampled before any commit landing on the same edge.
  always_comb begin
    ar_idx_s    = addr_idx(araddr);
    ar_ok_s     = addr_ok(araddr);
    rd_val_s    = {DATA_WIDTH{1'b0}};
    rvalid_nx_s = rvalid_r;
    if (!ar_ok_s) rd_val_s = {DATA_WIDTH{1'b0}};
    else if (RO_MASK[ar_idx_s]) rd_val_s = reg_in_s[ar_idx_s];
    else rd_val_s = regs_r[ar_idx_s];
    if (ar_hs_s) rvalid_nx_s = 1'b1;
    else if (rvalid_r && rready) rvalid_nx_s = 1'b0;
    else rvalid_nx_s = rvalid_r;
  end

  // Read channel registers; rdata/rresp only move on an AR handshake.
  always_ff @(posedge axi4l_aclk) begin
    if (axi4l_arst) begin
      arready_r <= 1'b0;
      rvalid_r  <= 1'b0;
      rdata_r   <= {DATA_WIDTH{1'b0}};
      rresp_r   <= RESP_OKAY;
    end else begin
      rvalid_r  <= rvalid_nx_s;
      arready_r <= !rvalid_nx_s;
      if (ar_hs_s) begin
        rdata_r <= rd_val_s;
        rresp_r <= ar_ok_s ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  assign awready  = awready_r;
  assign wready   = wready_r;
  assign bvalid   = bvalid_r;
  assign bresp    = bresp_r;
  assign arready  = arready_r;
  assign rvalid   = rvalid_r;
  assign rdata    = rdata_r;
  assign rresp    = rresp_r;
  assign wr_pulse = wr_pulse_r;

endmodule

// File: tb/tb_axi4l_regfile.sv
// Self-checking bench for axi4l_regfile: transaction-level reference model plus directed and random traffic.
module tb_axi4l_regfile;

  localparam logic [15:0] RO = 16'h8008;

  logic         clk = 1'b0;
  logic         axi4l_arst;
  logic [31:0]  awaddr, araddr, wdata, rdata;
  logic [3:0]   wstrb;
  logic         awvalid, awready, wvalid, wready, bvalid, bready;
  logic         arvalid, arready, rvalid, rready;
  logic [1:0]   bresp, rresp;
  logic [511:0] reg_out, reg_in;
  logic [15:0]  wr_pulse;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;
  logic [31:0] model_regs [16];
  logic [15:0] exp_pulse = 16'd0;

  axi4l_regfile #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(16), .RO_MASK(RO)) dut (
    .axi4l_aclk(clk), .axi4l_arst(axi4l_arst),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .reg_out(reg_out), .reg_in(reg_in), .wr_pulse(wr_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [511:0] rand_reg_in();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = {26'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
    if ($urandom_range(0, 7) == 0) a[$urandom_range(6, 31)] = 1'b1;
    return a;
  endfunction

  // Reference check: R/W slots follow the model, RO slots read 0, strobe only on a good write.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 16; i++) chk("reg_out", reg_out[i*32 +: 32], RO[i] ? 32'd0 : model_regs[i]);
      chk("wr_pulse", wr_pulse, exp_pulse);
      exp_pulse = 16'd0;
    end
  end

  // Called at a negedge; returns at the negedge after the B handshake.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int b_dly);
    bit to;
    logic ok;
    logic [3:0] idx;
    logic [1:0] exp_resp;
    to = 1'b0;
    bready = 1'b0;
    fork
      begin
        repeat (aw_dly) @(negedge clk);
        awaddr = addr; awvalid = 1'b1;
        for (int n = 0; n < 20 && !awready; n++) @(negedge clk);
        if (!awready) to = 1'b1;
        else begin @(negedge clk); chk("awready_after_hs", awready, 1'b0); end
        awvalid = 1'b0;
      end
      begin
        repeat (w_dly) @(negedge clk);
        wdata = data; wstrb = strb; wvalid = 1'b1;
        for (int n = 0; n < 20 && !wready; n++) @(negedge clk);
        if (!wready) to = 1'b1;
        else begin @(negedge clk); chk("wready_after_hs", wready, 1'b0); end
        wvalid = 1'b0;
      end
    join
    if (to) begin
      tests++; fails++;
      $display("FAIL write_handshake_timeout: got no ready, expected ready within 20 cycles");
      return;
    end
    chk("bvalid_early", bvalid, 1'b0);
    idx = addr[5:2];
    ok = (addr[31:6] == 26'd0) && !RO[idx];
    exp_resp = ok ? 2'b00 : 2'b10;
    @(posedge clk); #1;
    if (ok) begin
      for (int b = 0; b < 4; b++) if (strb[b]) model_regs[idx][b*8 +: 8] = data[b*8 +: 8];
      exp_pulse = 16'd1 << idx;
    end
    @(negedge clk);
    chk("bvalid", bvalid, 1'b1);
    chk("bresp", bresp, exp_resp);
    chk("awready_busy", awready, 1'b0);
    chk("wready_busy", wready, 1'b0);
    for (int i = 0; i < b_dly; i++) begin
      @(negedge clk);
      chk("bvalid_hold", bvalid, 1'b1);
      chk("bresp_hold", bresp, exp_resp);
      chk("awready_hold", awready, 1'b0);
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    chk("bvalid_clear", bvalid, 1'b0);
    chk("awready_back", awready, 1'b1);
    chk("wready_back", wready, 1'b1);
  endtask

  // Called at a negedge; returns at the negedge after the R handshake.
  task automatic do_read(input logic [31:0] addr, input int r_dly,
                         output logic [31:0] got, output logic [1:0] got_resp);
    logic [31:0] exp_d;
    logic [1:0] exp_r;
    logic [3:0] idx;
    got = 32'd0; got_resp = 2'b00;
    rready = 1'b0;
    araddr = addr; arvalid = 1'b1;
    for (int n = 0; n < 20 && !arready; n++) @(negedge clk);
    if (!arready) begin
      arvalid = 1'b0;
      tests++; fails++;
      $display("FAIL read_handshake_timeout: got no arready, expected arready within 20 cycles");
      return;
    end
    idx = addr[5:2];
    if (addr[31:6] != 26'd0) begin exp_d = 32'd0; exp_r = 2'b10; end
    else if (RO[idx]) begin exp_d = reg_in[idx*32 +: 32]; exp_r = 2'b00; end
    else begin exp_d = model_regs[idx]; exp_r = 2'b00; end
    @(negedge clk);
    arvalid = 1'b0;
    got = rdata; got_resp = rresp;
    chk("rvalid", rvalid, 1'b1);
    chk("rdata", rdata, exp_d);
    chk("rresp", rresp, exp_r);
    chk("arready_busy", arready, 1'b0);
    for (int i = 0; i < r_dly; i++) begin
      reg_in = rand_reg_in();
      @(negedge clk);
      chk("rvalid_hold", rvalid, 1'b1);
      chk("rdata_hold", rdata, exp_d);
      chk("arready_hold", arready, 1'b0);
    end
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    chk("rvalid_clear", rvalid, 1'b0);
    chk("arready_back", arready, 1'b1);
  endtask

  task automatic apply_reset();
    chk_en = 1'b0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    axi4l_arst = 1'b1;
    @(negedge clk);
    chk("rst_awready", awready, 1'b0);
    chk("rst_wready", wready, 1'b0);
    chk("rst_arready", arready, 1'b0);
    chk("rst_bvalid", bvalid, 1'b0);
    chk("rst_rvalid", rvalid, 1'b0);
    chk("rst_bresp", bresp, 2'b00);
    chk("rst_rresp", rresp, 2'b00);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_wr_pulse", wr_pulse, 16'd0);
    chk("rst_reg_out_zero", reg_out == 512'd0, 1'b1);
    for (int i = 0; i < 16; i++) model_regs[i] = 32'd0;
    exp_pulse = 16'd0;
    axi4l_arst = 1'b0;
    @(negedge clk);
    chk("ready_aw_after_rst", awready, 1'b1);
    chk("ready_w_after_rst", wready, 1'b1);
    chk("ready_ar_after_rst", arready, 1'b1);
    chk_en = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish before 2 ms");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got, a;
    logic [1:0] gr;
    axi4l_arst = 1'b1;
    awaddr = 32'd0; awvalid = 1'b0; wdata = 32'd0; wstrb = 4'd0; wvalid = 1'b0;
    bready = 1'b0; araddr = 32'd0; arvalid = 1'b0; rready = 1'b0; reg_in = 512'd0;
    for (int i = 0; i < 16; i++) model_regs[i] = 32'd0;
    repeat (2) @(negedge clk);
    apply_reset();

    for (int i = 0; i < 16; i++) begin
      do_read(32'(i) << 2, 0, got, gr);
      chk("reset_read_data", got, 32'h0000_0000);
      chk("reset_read_resp", gr, 2'b00);
    end

    do_write(32'h08, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
    chk("reg2_full", reg_out[95:64], 32'hDEAD_BEEF);
    do_write(32'h08, 32'h0000_5500, 4'h2, 0, 0, 1);
    chk("reg2_strb", reg_out[95:64], 32'hDEAD_55EF);
    do_write(32'h08, 32'hFFFF_FFFF, 4'h0, 1, 0, 0);
    chk("reg2_nostrb", reg_out[95:64], 32'hDEAD_55EF);

    do_write(32'h04, 32'h1234_5678, 4'hF, 3, 0, 4);
    chk("reg1_w_first", reg_out[63:32], 32'h1234_5678);

    do_write(32'h40, 32'hAAAA_AAAA, 4'hF, 0, 0, 0);
    do_write(32'h0C, 32'hBBBB_BBBB, 4'hF, 0, 2, 0);
    do_read(32'h40, 0, got, gr);
    chk("oor_read_data", got, 32'd0);
    chk("oor_read_resp", gr, 2'b10);
    reg_in[3*32 +: 32] = 32'hCAFE_F00D;
    do_read(32'h0C, 0, got, gr);
    chk("ro_read_data", got, 32'hCAFE_F00D);
    chk("ro_read_resp", gr, 2'b00);

    do_write(32'h14, 32'h11, 4'hF, 0, 0, 0);
    fork
      do_write(32'h14, 32'h22, 4'hF, 0, 0, 0);
      begin
        @(negedge clk);
        do_read(32'h14, 3, got, gr);
      end
    join
    chk("same_edge_old", got, 32'h11);
    do_read(32'h14, 0, got, gr);
    chk("same_edge_new", got, 32'h22);

    for (int t = 0; t < 40; t++) begin
      reg_in = rand_reg_in();
      a = rand_addr();
      case ($urandom_range(0, 2))
        0: do_write(a, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
        1: do_read(a, $urandom_range(0, 2), got, gr);
        default: fork
          do_write(a, $urandom, 4'($urandom), $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
          do_read(rand_addr(), $urandom_range(0, 2), got, gr);
        join
      endcase
    end

    // Reset while AW is held: the orphaned address must not pair with a later W.
    awaddr = 32'h1C; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    chk("aw_held_ready", awready, 1'b0);
    apply_reset();
    wdata = 32'h5555_5555; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    bready = 1'b1;
    repeat (4) begin @(negedge clk); chk("no_b_orphan_aw", bvalid, 1'b0); end
    bready = 1'b0;
    apply_reset();

    // Reset with a B and an R response pending: neither may appear after release.
    do_write(32'h18, 32'h7777_7777, 4'hF, 0, 0, 0);
    chk_en = 1'b0;
    awaddr = 32'h18; awvalid = 1'b1; wdata = 32'h9999_9999; wstrb = 4'hF; wvalid = 1'b1;
    araddr = 32'h18; arvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(negedge clk);
    chk("pending_bvalid", bvalid, 1'b1);
    chk("pending_rvalid", rvalid, 1'b1);
    apply_reset();
    bready = 1'b1; rready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("no_b_after_rst", bvalid, 1'b0);
      chk("no_r_after_rst", rvalid, 1'b0);
    end
    bready = 1'b0; rready = 1'b0;
    chk("reg6_cleared", reg_out[223:192], 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
